// File: rtl/reg_operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// reg_operand_fetch_pkg
// Shared definitions for the register-bank operand fetch path:
//   - fetch FSM state encoding
//   - register count / index width
//   - one-hot write-enable decoder (valid flag plus index), usable by any
//     block that watches the bank write port
// -----------------------------------------------------------------------------
package reg_operand_fetch_pkg;

  localparam int NREGS = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_res_t;

  // Decode a bank write enable: valid only when exactly one bit is set.
  function automatic onehot_res_t onehot_check(input logic [NREGS-1:0] en);
    onehot_res_t res;
    logic [3:0]  cnt;
    res.valid = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    cnt       = 4'd0;
    for (int i = 0; i < NREGS; i++) begin
      if (en[i]) begin
        cnt     = cnt + 4'd1;
        res.idx = i[IDX_W-1:0];
      end else begin
        cnt     = cnt;
      end
    end
    res.valid = (cnt == 4'd1);
    return res;
  endfunction

endpackage

// File: rtl/reg_operand_fetch_if.sv
// -----------------------------------------------------------------------------
// reg_operand_fetch_if
// Request and result handshakes of the operand fetch block.
//   req_valid / req_ready / src_a / src_b : fetch request (issue side)
//   out_valid / out_ready / op_a / op_b   : operands to execute stage
// Modports:
//   master : issue/execute side (drives requests, consumes operands)
//   slave  : the fetch block
// -----------------------------------------------------------------------------
interface reg_operand_fetch_if
  import reg_operand_fetch_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] src_a;
  logic [IDX_W-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  modport master (
    output req_valid, src_a, src_b, out_ready,
    input  req_ready, out_valid, op_a, op_b
  );

  modport slave (
    input  req_valid, src_a, src_b, out_ready,
    output req_ready, out_valid, op_a, op_b
  );

endinterface

// File: rtl/reg_bypass_mux.sv
// -----------------------------------------------------------------------------
// reg_bypass_mux
// Combinational read mux for one operand with write forwarding.
// Ports:
//   idx      in  register index to read
//   q0..q7   in  current bank outputs
//   wr_en    in  bank write enable (expected one-hot)
//   wr_data  in  bank write data
//   sel_data out wr_data when a valid one-hot write targets idx, else q[idx]
//   hit      out a valid one-hot write targets idx this cycle
// -----------------------------------------------------------------------------
module reg_bypass_mux
  import reg_operand_fetch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  input  logic [WIDTH-1:0] q5,
  input  logic [WIDTH-1:0] q6,
  input  logic [WIDTH-1:0] q7,
  input  logic [NREGS-1:0] wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] sel_data,
  output logic             hit
);

  onehot_res_t      wr_dec_s;
  logic [WIDTH-1:0] q_sel_s;

  // Forward only a clean one-hot write; multi-bit enables never bypass.
  always_comb begin
    wr_dec_s = onehot_check(wr_en);
    if (wr_dec_s.valid && (wr_dec_s.idx == idx)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // Plain register read.
  always_comb begin
    q_sel_s = {WIDTH{1'b0}};
    case (idx)
      3'd0:    q_sel_s = q0;
      3'd1:    q_sel_s = q1;
      3'd2:    q_sel_s = q2;
      3'd3:    q_sel_s = q3;
      3'd4:    q_sel_s = q4;
      3'd5:    q_sel_s = q5;
      3'd6:    q_sel_s = q6;
      3'd7:    q_sel_s = q7;
      default: q_sel_s = {WIDTH{1'b0}};
    endcase
  end

  // Forwarded value takes priority over the stale register value.
  always_comb begin
    if (hit) begin
      sel_data = wr_data;
    end else begin
      sel_data = q_sel_s;
    end
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// -----------------------------------------------------------------------------
// reg_operand_fetch
// Read side of the 8x16 register bank. Accepts a two-operand fetch, reads the
// bank one cycle later (with same-cycle write forwarding), then holds the
// operands for the execute stage, tracking bank writes until consumed.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     req_valid/req_ready/src_a/src_b, out_valid/out_ready/op_a/op_b
//   q0..q7          bank outputs
//   wr_en, wr_data  bank write port (one-hot enable)
//   bypass_err      sticky: a multi-bit wr_en was observed
//   fetch_count     completed fetches, wraps at 16 bits
// -----------------------------------------------------------------------------
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_operand_fetch_if.slave   bus,
  input  logic [WIDTH-1:0]     q0,
  input  logic [WIDTH-1:0]     q1,
  input  logic [WIDTH-1:0]     q2,
  input  logic [WIDTH-1:0]     q3,
  input  logic [WIDTH-1:0]     q4,
  input  logic [WIDTH-1:0]     q5,
  input  logic [WIDTH-1:0]     q6,
  input  logic [WIDTH-1:0]     q7,
  input  logic [NREGS-1:0]     wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 bypass_err,
  output logic [15:0]          fetch_count
);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [IDX_W-1:0] idx_a_r;
  logic [IDX_W-1:0] idx_b_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             hit_a_s;
  logic             hit_b_s;
  logic             req_ready_r;
  logic             out_valid_r;
  logic             bypass_err_r;
  logic [15:0]      fetch_count_r;
  logic             wr_multi_s;

  // Muxes index the latched sources: in READ they produce the fetched value,
  // in HOLD their hit flags mark operands overwritten by the bank.
  reg_bypass_mux #(.WIDTH(WIDTH)) u_mux_a (
    .idx      (idx_a_r),
    .q0       (q0), .q1 (q1), .q2 (q2), .q3 (q3),
    .q4       (q4), .q5 (q5), .q6 (q6), .q7 (q7),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .sel_data (sel_a_s),
    .hit      (hit_a_s)
  );

  reg_bypass_mux #(.WIDTH(WIDTH)) u_mux_b (
    .idx      (idx_b_r),
    .q0       (q0), .q1 (q1), .q2 (q2), .q3 (q3),
    .q4       (q4), .q5 (q5), .q6 (q6), .q7 (q7),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .sel_data (sel_b_s),
    .hit      (hit_b_s)
  );

  // More than one enable bit set: clearing the lowest set bit leaves bits.
  always_comb begin
    if ((wr_en & (wr_en - 8'd1)) != 8'd0) begin
      wr_multi_s = 1'b1;
    end else begin
      wr_multi_s = 1'b0;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: state_nxt_s = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == HOLD);
    end
  end

  // Index latch and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a_r <= {IDX_W{1'b0}};
      idx_b_r <= {IDX_W{1'b0}};
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            idx_a_r <= bus.src_a;
            idx_b_r <= bus.src_b;
          end
        end
        READ: begin
          op_a_r <= sel_a_s;
          op_b_r <= sel_b_s;
        end
        HOLD: begin
          // A consuming handshake takes the operands as they are.
          if (!bus.out_ready) begin
            if (hit_a_s) op_a_r <= wr_data;
            if (hit_b_s) op_b_r <= wr_data;
          end
        end
        default: begin
          op_a_r <= op_a_r;
          op_b_r <= op_b_r;
        end
      endcase
    end
  end

  // Sticky enable-error flag and completed-fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_err_r  <= 1'b0;
      fetch_count_r <= 16'd0;
    end else begin
      if (wr_multi_s) bypass_err_r <= 1'b1;
      if ((state_r == HOLD) && bus.out_ready) begin
        fetch_count_r <= fetch_count_r + 16'd1;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.op_a      = op_a_r;
  assign bus.op_b      = op_b_r;
  assign bypass_err    = bypass_err_r;
  assign fetch_count   = fetch_count_r;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_reg_operand_fetch
// Directed bench for reg_operand_fetch. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] q [8];
  logic [7:0]  wr_en;
  logic [15:0] wr_data;
  logic        bypass_err;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  reg_operand_fetch_if #(.WIDTH(16)) bus ();

  reg_operand_fetch #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .q0          (q[0]), .q1 (q[1]), .q2 (q[2]), .q3 (q[3]),
    .q4          (q[4]), .q5 (q[5]), .q6 (q[6]), .q7 (q[7]),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .bypass_err  (bypass_err),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Full fetch with out_ready already high: request, READ, HOLD, consume.
  task automatic fetch(input logic [2:0] a, input logic [2:0] b);
    bus.req_valid = 1'b1;
    bus.src_a     = a;
    bus.src_b     = b;
    nedge();
    bus.req_valid = 1'b0;
    nedge();
    nedge();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.src_a     = 3'd0;
    bus.src_b     = 3'd0;
    bus.out_ready = 1'b0;
    wr_en         = 8'd0;
    wr_data       = 16'd0;
    for (int i = 0; i < 8; i++) q[i] = 16'd0;
    nedge();
    nedge();

    // Reset state
    chk("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_op_a", bus.op_a, 16'h0000);
    chk("rst_op_b", bus.op_b, 16'h0000);
    chk("rst_bypass_err", {15'd0, bypass_err}, 16'd0);
    chk("rst_count", fetch_count, 16'd0);
    rst_n = 1'b1;
    nedge();

    // Basic fetch, 2-edge latency
    q[3] = 16'h1234;
    q[5] = 16'hBEEF;
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd3;
    bus.src_b     = 3'd5;
    nedge();
    bus.req_valid = 1'b0;
    chk("basic_read_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("basic_read_ready", {15'd0, bus.req_ready}, 16'd0);
    nedge();
    chk("basic_hold_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("basic_op_a", bus.op_a, 16'h1234);
    chk("basic_op_b", bus.op_b, 16'hBEEF);
    nedge();
    chk("basic_done_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("basic_done_ready", {15'd0, bus.req_ready}, 16'd1);
    chk("basic_count", fetch_count, 16'd1);

    // Bypass during READ, A == B
    q[2] = 16'h0001;
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd2;
    bus.src_b     = 3'd2;
    nedge();
    bus.req_valid = 1'b0;
    wr_en   = 8'b0000_0100;
    wr_data = 16'h00AA;
    nedge();
    wr_en   = 8'd0;
    chk("byp_op_a", bus.op_a, 16'h00AA);
    chk("byp_op_b", bus.op_b, 16'h00AA);
    nedge();
    chk("byp_count", fetch_count, 16'd2);

    // Hold coherence, then handshake wins over a simultaneous write
    q[6] = 16'h0010;
    q[1] = 16'h0020;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd6;
    bus.src_b     = 3'd1;
    nedge();
    bus.req_valid = 1'b0;
    nedge();
    chk("hold_op_a_init", bus.op_a, 16'h0010);
    chk("hold_op_b_init", bus.op_b, 16'h0020);
    wr_en   = 8'b0100_0000;
    wr_data = 16'h7777;
    nedge();
    chk("hold_op_a_upd", bus.op_a, 16'h7777);
    chk("hold_op_b_keep", bus.op_b, 16'h0020);
    chk("hold_valid", {15'd0, bus.out_valid}, 16'd1);
    bus.out_ready = 1'b1;
    wr_data = 16'h1111;
    nedge();
    wr_en = 8'd0;
    chk("hold_consumed_op_a", bus.op_a, 16'h7777);
    chk("hold_consumed_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("hold_count", fetch_count, 16'd3);
    chk("hold_no_err", {15'd0, bypass_err}, 16'd0);

    // Invalid (two-hot) enable during READ
    q[0] = 16'h0005;
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd0;
    bus.src_b     = 3'd5;
    nedge();
    bus.req_valid = 1'b0;
    wr_en   = 8'b0000_0011;
    wr_data = 16'hFFFF;
    nedge();
    wr_en   = 8'd0;
    chk("inv_op_a", bus.op_a, 16'h0005);
    chk("inv_op_b", bus.op_b, 16'hBEEF);
    chk("inv_err", {15'd0, bypass_err}, 16'd1);
    nedge();
    for (int n = 0; n < 10; n++) fetch(3'd3, 3'd5);
    chk("inv_err_sticky", {15'd0, bypass_err}, 16'd1);
    chk("inv_count", fetch_count, 16'd14);
    chk("inv_last_op_a", bus.op_a, 16'h1234);

    // Asynchronous reset while in HOLD
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd3;
    bus.src_b     = 3'd5;
    nedge();
    bus.req_valid = 1'b0;
    nedge();
    chk("mid_hold_valid", {15'd0, bus.out_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("mid_rst_ready", {15'd0, bus.req_ready}, 16'd1);
    chk("mid_rst_op_a", bus.op_a, 16'h0000);
    chk("mid_rst_op_b", bus.op_b, 16'h0000);
    chk("mid_rst_count", fetch_count, 16'd0);
    chk("mid_rst_err", {15'd0, bypass_err}, 16'd0);
    nedge();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    nedge();
    bus.req_valid = 1'b1;
    bus.src_a     = 3'd5;
    bus.src_b     = 3'd3;
    nedge();
    bus.req_valid = 1'b0;
    nedge();
    chk("post_rst_op_a", bus.op_a, 16'hBEEF);
    chk("post_rst_op_b", bus.op_b, 16'h1234);
    nedge();
    chk("post_rst_count", fetch_count, 16'd1);

    // Counter wrap: start two fetches below the top of the range
    force dut.fetch_count_r = 16'hFFFE;
    #1;
    release dut.fetch_count_r;
    nedge();
    chk("wrap_preload", fetch_count, 16'hFFFE);
    fetch(3'd1, 3'd2);
    chk("wrap_top", fetch_count, 16'hFFFF);
    fetch(3'd1, 3'd2);
    chk("wrap_zero", fetch_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_operand_fetch.md
Name: reg_operand_fetch

Overview:
- Read side of the 8x16 register bank.
- Accepts a two-operand fetch request (source indices A and B) over a valid/ready handshake, then reads the bank's q0..q7 outputs.
- Forwards a same-cycle bank write (one-hot enable plus data) ahead of the stale register value.
- Presents both operands to the execute stage over a second valid/ready handshake; held operands stay coherent with later bank writes until consumed.

Parameters:
WIDTH, 16, data width of each register and operand
NREGS, 8, register count; fixed at 8 (one-hot enable width, 3-bit index)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request
src_a  in  3  index of operand A
src_b  in  3  index of operand B
q0..q7  in  WIDTH each  current register bank outputs
wr_en  in  8  bank write enable, one-hot (same signal driving the bank)
wr_data  in  WIDTH  bank write data
out_valid  out  1  op_a/op_b valid
out_ready  in  1  consumer accepts operands
op_a  out  WIDTH  operand A
op_b  out  WIDTH  operand B
bypass_err  out  1  sticky: wr_en seen with more than one bit set
fetch_count  out  16  completed fetches, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; out_valid=0; op_a=op_b=0; bypass_err=0; fetch_count=0; latched indices=0.
  - Reset mid-operation aborts the fetch; no output handshake occurs.
- FSM states: IDLE, READ, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch src_a/src_b and go to READ.
- READ:
  - req_ready=0.
  - At the next edge, op_a<=sel(idx_a) and op_b<=sel(idx_b); out_valid<=1; go to HOLD.
  - Latency: 2 edges from request acceptance to out_valid=1.
- sel(i):
  - If wr_en is exactly one-hot and wr_en[i]=1, the result is wr_data (bypass).
  - Otherwise the result is q_i.
  - A == B is legal; both operands get the same value.
- HOLD:
  - out_valid=1, req_ready=0.
  - If out_ready=1 at an edge: out_valid<=0, fetch_count<=fetch_count+1 (mod 2^16), go to IDLE.
  - If out_ready=0: for each operand whose latched index matches a valid one-hot wr_en, update that operand to wr_data. Other operands are unchanged.
  - If out_ready=1 and a write occur in the same edge, the handshake wins: the operands are consumed unchanged.
- No back-to-back acceptance: a new request is accepted only in IDLE, so the minimum period is 3 cycles per fetch.
- req_valid may drop without acceptance; no state changes.
- wr_en handling:
  - wr_en=0: no bypass or update.
  - wr_en with popcount>1: no bypass or update from that cycle, and bypass_err<=1. bypass_err stays set until reset.
- Outputs are all registered; no combinational path from inputs to outputs except none (req_ready derives from state only).

Decomposition:
- Shared package holds:
  - the FSM state encoding: IDLE=2'd0, READ=2'd1, HOLD=2'd2;
  - NREGS=8 and IDX_W=3;
  - a one-hot check function (returns valid flag plus index), also usable by the bank.
- One sub-module is natural: reg_bypass_mux (combinational).
  - Inputs: index, q0..q7, wr_en, wr_data.
  - Outputs: the selected value and a hit flag.
  - Instantiated twice, once for A and once for B.

Test Plan:
- Basic fetch: q3=0x1234, q5=0xBEEF, request src_a=3, src_b=5 with out_ready=1 -> out_valid is 1 exactly 2 edges after acceptance, op_a=0x1234, op_b=0xBEEF, fetch_count=1, back to IDLE with req_ready=1.
- Bypass in READ: q2=0x0001, and in the READ cycle wr_en=8'b00000100 with wr_data=0x00AA, request A=2, B=2 -> op_a=op_b=0x00AA.
- Hold coherence:
  - Setup: out_ready=0 in HOLD with A=6 (op_a=0x0010); write wr_en=8'b01000000, wr_data=0x7777 -> op_a becomes 0x7777 and op_b is unchanged.
  - Then raise out_ready together with another write of 0x1111 -> op_a consumed as 0x7777.
- Invalid enable: wr_en=8'b00000011 during READ with A=0, q0=0x0005 -> op_a=0x0005 and bypass_err=1, still 1 after 10 further fetches.
- Reset mid-operation: assert rst_n=0 during HOLD -> out_valid=0, op_a=op_b=0, fetch_count=0, req_ready=1 immediately (asynchronous); after release a new fetch completes normally.
- Counter wrap: preload via 65535 fetches, then one more -> fetch_count=0x0000.
